serial_word_feeder: RTL
=======================

// Module: serial_word_feeder
// PURPOSE
//  Upstream feeder for the dynamic serial shift register: accepts parallel words on a valid/ready
//  handshake and serialises them MSB-first onto a bit stream plus clock-enable strobe that drive
//  the register's D and CE inputs directly. Also latches a per-word tap address for its A input.
//  Supports zero-bubble back-to-back streaming and an optional trailing parity bit.
// PARAMETERS
//  WIDTH  8  data word width in bits, legal 2..16
//  TAP_W  4  tap-address width; matches the downstream register's A port (16 taps)
//  CNT_W  derived localparam = ceil(log2(WIDTH)); bit-counter width, not overridable
// PORTS
//  CLK        in   1      rising-edge clock, single domain
//  RST_N      in   1      asynchronous active-low reset
//  DIN        in   WIDTH  parallel word to serialise
//  DIN_VALID  in   1      DIN and TAP_SEL are valid
//  DIN_READY  out  1      feeder accepts a word this cycle; transfer = DIN_VALID & DIN_READY
//  TAP_SEL    in   TAP_W  tap address captured with the word
//  SOUT       out  1      serial data to downstream D
//  SOUT_CE    out  1      shift strobe to downstream CE; SOUT is meaningful only while high
//  TAP_A      out  TAP_W  latched tap address to downstream A
//  BUSY       out  1      a word (or its parity bit) is being emitted
//  DONE       out  1      high in the cycle the final bit of a word is on SOUT
// BEHAVIOUR
//  Reset (RST_N low, async): state=IDLE, shift reg=0, cnt=0, parity=0, TAP_A=0.
//   Outputs during and after reset: SOUT=0, SOUT_CE=0, BUSY=0, DONE=0, DIN_READY=1.
//   DIN_VALID is ignored while RST_N is low.
//  FSM states: IDLE, SHIFT, PAR (PAR exists only when the macro is defined).
//  IDLE: DIN_READY=1. On a transfer: sreg<=DIN, TAP_A<=TAP_SEL, cnt<=0, parity<=^DIN, go to SHIFT.
//  SHIFT: SOUT=sreg[WIDTH-1], SOUT_CE=1, BUSY=1. Each clock: sreg<=sreg<<1, cnt<=cnt+1.
//  Latency: bit k of a word (k=0 is MSB) is on SOUT in the (k+1)th cycle after the transfer edge.
//  Last data bit is emitted when cnt==WIDTH-1. Next state from that cycle:
//   - parity off, transfer in the same cycle: reload exactly as from IDLE, stay in SHIFT.
//     Zero gap between words; DIN_READY=1 in this cycle only.
//   - parity off, no transfer: go to IDLE.
//   - parity on: go to PAR. DIN_READY=0 in this cycle.
//  PAR: SOUT=parity (even: the total number of 1s, including this bit, is even), SOUT_CE=1.
//   DIN_READY=1. A transfer in this cycle reloads into SHIFT; otherwise go to IDLE.
//  DONE=1 in the final emitted bit's cycle: the last data bit with parity off, the PAR cycle with it on.
//  SOUT is forced to 0 whenever SOUT_CE=0. SOUT, SOUT_CE and DIN_READY decode from registers only.
//  TAP_A changes only on a transfer edge. It holds through IDLE, so the downstream tap stays stable.
//  DIN and TAP_SEL are sampled only on the transfer edge; changes at other times have no effect.
//  Reset mid-word: the word is discarded, SOUT_CE drops immediately (async), and no DONE is issued.
//  cnt never exceeds WIDTH-1; wrap-around is impossible by construction.
// CONFIGURATION
//  Macro SERIAL_WORD_FEEDER_PARITY_EN:
//   defined     -> PAR state present; WIDTH+1 strobes per word; back-to-back words have no gap.
//   not defined -> no PAR state or parity register; exactly WIDTH strobes per word.
// STRUCTURE
//  Shared include shift_reg_defs.vh holds the state encodings (ST_IDLE=2'd0, ST_SHIFT=2'd1,
//   ST_PAR=2'd2) and the default TAP_W=4, used by all shift-register blocks.
//  One natural sub-module: serial_bit_counter (load/increment, last-bit flag at WIDTH-1).
//  The FSM, shift register and output decode stay in the top module.
// TESTING  (WIDTH=8 unless noted)
//  1 Reset: RST_N=0 with DIN_VALID=1 -> SOUT_CE=0, SOUT=0, TAP_A=0, BUSY=0, DONE=0, DIN_READY=1;
//    no word is accepted.
//  2 Single word DIN=8'hA5, TAP_SEL=4'd3, parity off -> SOUT=1,0,1,0,0,1,0,1 on cycles 1..8;
//    SOUT_CE high 8 cycles; TAP_A=3 from cycle 1; DONE only in cycle 8; then idle.
//  3 Back-to-back 8'hA5 then 8'h3C, DIN_VALID held -> 16 contiguous SOUT_CE cycles;
//    DIN_READY high only in cycle 8 of word 1.
//  4 Reset mid-word: assert RST_N=0 during bit 4 of 8'hFF -> SOUT_CE=0 at once; no DONE;
//    the next word 8'h81 after release serialises cleanly.
//  5 Parity on: 8'hA5 -> 9 strobes, parity bit 0; 8'h07 -> parity bit 1;
//    DONE in cycle 9; back-to-back word starts in cycle 10.
//  6 Feeder driving the dynamic shift register model with TAP_SEL=4'd7, stream 8'hA5 ->
//    the register's Q equals the bit fed 8 strobes earlier (tap 7 holds the 8th-most-recent bit).

Source files
------------

// File: rtl/serial_word_feeder_pkg.sv
// serial_word_feeder_pkg
//   Shared definitions for the serial word feeder: FSM state encoding and the
//   default tap-address width of the downstream dynamic shift register.
//   The encodings are fixed (IDLE=0, SHIFT=1, PAR=2) so other shift-register
//   blocks can decode the same state values.
package serial_word_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;

    // Downstream register has 16 taps.
    localparam int TAP_W_DEF = 4;

endpackage

// File: rtl/serial_bit_counter.sv
// serial_bit_counter
//   Bit-position counter for the serialiser. Cleared on load, advanced on inc,
//   and flags the last data bit (count == WIDTH-1).
// Ports:
//   clk   in  rising-edge clock
//   rst_n in  asynchronous active-low reset
//   load  in  clear count to 0 (a new word is being captured)
//   inc   in  advance count by one
//   last  out count is at WIDTH-1
module serial_bit_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic inc,
    output logic last
);

    logic [CNT_W-1:0] cnt;

    // The FSM only asserts inc while last is low, so cnt never passes WIDTH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_word_feeder.sv
// serial_word_feeder
//   Accepts parallel words on a valid/ready handshake and serialises them
//   MSB-first onto sout with a shift strobe sout_ce, feeding the D/CE inputs of
//   a dynamic shift register. The tap address captured with each word drives
//   the register's A input and holds until the next accepted word.
//   Optional trailing even-parity bit: define SERIAL_WORD_FEEDER_PARITY_EN.
// Ports:
//   clk       in  rising-edge clock
//   rst_n     in  asynchronous active-low reset
//   din       in  parallel word
//   din_valid in  din / tap_sel valid
//   din_ready out word accepted this cycle when din_valid is high
//   tap_sel   in  tap address captured with the word
//   sout      out serial data (0 whenever sout_ce is low)
//   sout_ce   out shift strobe
//   tap_a     out latched tap address
//   busy      out a word or its parity bit is being emitted
//   done      out final bit of a word is on sout
module serial_word_feeder
    import serial_word_feeder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAP_W = TAP_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [TAP_W-1:0] tap_sel,
    output logic             sout,
    output logic             sout_ce,
    output logic [TAP_W-1:0] tap_a,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg;
    logic             xfer;
    logic             last;
    logic             load;
    logic             inc;
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
    logic             parity;
`endif

    assign xfer = din_valid & din_ready;

    serial_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .inc   (inc),
        .last  (last)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and counter control
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        inc       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    load      = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!last) begin
                    inc = 1'b1;
                end else begin
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
                    state_nxt = ST_PAR;
`else
                    // Reload on the last bit so words stream with no gap.
                    if (xfer) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
`endif
                end
            end
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
            ST_PAR: begin
                if (xfer) begin
                    load      = 1'b1;
                    state_nxt = ST_SHIFT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: shift register, tap address and parity capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg  <= '0;
            tap_a <= '0;
        end else if (load) begin
            sreg  <= din;
            tap_a <= tap_sel;
        end else if (state == ST_SHIFT) begin
            sreg  <= {sreg[WIDTH-2:0], 1'b0};
        end
    end

`ifdef SERIAL_WORD_FEEDER_PARITY_EN
    // XOR of the word is the even-parity bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity <= 1'b0;
        end else if (load) begin
            parity <= ^din;
        end
    end
`endif

    // Output decode: everything derives from registered state only.
    always_comb begin
        din_ready = 1'b0;
        sout      = 1'b0;
        sout_ce   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                din_ready = 1'b1;
            end
            ST_SHIFT: begin
                sout    = sreg[WIDTH-1];
                sout_ce = 1'b1;
                busy    = 1'b1;
`ifndef SERIAL_WORD_FEEDER_PARITY_EN
                din_ready = last;
                done      = last;
`endif
            end
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
            ST_PAR: begin
                sout      = parity;
                sout_ce   = 1'b1;
                busy      = 1'b1;
                din_ready = 1'b1;
                done      = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule
